// File: rtl/dbg_monitor_pkg.sv
// rtl/dbg_monitor_pkg.sv - shared types and jdo field constants for the debug memory monitor
package dbg_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } mon_state_t;

    localparam int JDO_READ_BIT = 34;
    localparam int JDO_ADDR_LSB = 2;
    localparam int JDO_DATA_MSB = 31;
    localparam int WORD_INCR    = 4;

endpackage

// File: rtl/dbg_monitor_mem_engine.sv
// rtl/dbg_monitor_mem_engine.sv - runs debug-host monitor reads/writes over an Avalon-MM master
module dbg_monitor_mem_engine
    import dbg_monitor_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    mon_state_t       state;
    logic [CNT_W-1:0] stall_cnt;
    logic             any_strobe;
    logic             unused_jdo;

    assign any_strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign avm_address    = MonAReg;
    assign avm_writedata  = MonDReg;
    assign avm_byteenable = 4'hF;
    assign unused_jdo     = ^{jdo[37:35], jdo[33:32]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            stall_cnt     <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            MonDReg       <= '0;
            MonAReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    // Write outranks address, which outranks continuation read.
                    if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[JDO_DATA_MSB:0];
                        avm_write     <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        state         <= WRITE;
                    end else if (take_action_ocimem_a) begin
                        MonAReg       <= {jdo[ADDR_W-1:JDO_ADDR_LSB], 2'b00};
                        monitor_error <= 1'b0;
                        if (jdo[JDO_READ_BIT]) begin
                            avm_read      <= 1'b1;
                            monitor_ready <= 1'b0;
                            state         <= READ;
                        end
                    end else if (take_no_action_ocimem_a) begin
                        avm_read      <= 1'b1;
                        monitor_ready <= 1'b0;
                        monitor_error <= 1'b0;
                        state         <= READ;
                    end
                end
                READ, WRITE: begin
                    // A command arriving mid-transfer is dropped but flagged.
                    if (any_strobe) begin
                        monitor_error <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        if (state == READ) begin
                            MonDReg <= avm_readdata;
                        end
                        MonAReg       <= MonAReg + ADDR_W'(WORD_INCR);
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        stall_cnt     <= '0;
                        state         <= IDLE;
                    end else if (stall_cnt == CNT_W'(TIMEOUT)) begin
                        avm_read      <= 1'b0;
                        avm_write     <= 1'b0;
                        monitor_ready <= 1'b1;
                        monitor_error <= 1'b1;
                        stall_cnt     <= '0;
                        state         <= IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_monitor_mem_engine.sv
// tb/tb_dbg_monitor_mem_engine.sv - randomized self-checking bench for dbg_monitor_mem_engine
module tb_dbg_monitor_mem_engine;

    localparam int TO = 7;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta, tn, tb;
    logic [31:0] avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] MonDReg, MonAReg;
    logic        monitor_ready, monitor_error;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_addr, m_data;
    logic        m_err;
    logic [31:0] mem [logic [31:0]];

    dbg_monitor_mem_engine #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta),
        .take_no_action_ocimem_a (tn),
        .take_action_ocimem_b    (tb),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_byteenable          (avm_byteenable),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(monitor_ready), 32'd1);
        check({tag, "_req"}, {30'd0, avm_read, avm_write}, 32'd0);
        check({tag, "_err"}, 32'(monitor_error), 32'(m_err));
        check({tag, "_areg"}, MonAReg, m_addr);
        check({tag, "_dreg"}, MonDReg, m_data);
    endtask

    function automatic logic [37:0] mk_jdo(input logic rd, input logic [31:0] v);
        return {3'b000, rd, 2'b00, v};
    endfunction

    // kind: 0 address command, 1 continuation read, 2 write
    task automatic run_cmd(input int kind, input logic [37:0] j, input int stalls,
                           input bit poke, input bit extra);
        int  xfer;
        int  c;
        bit  done;
        bit  stall;
        bit  accepted;
        logic [31:0] rdata;
        @(negedge clk);
        jdo = j;
        tb = (kind == 2);
        ta = (kind == 0) || (extra && kind == 2);
        tn = (kind == 1) || (extra && kind != 1);
        xfer = 0;
        if (kind == 2) begin
            m_data = j[31:0]; m_err = 1'b0; xfer = 2;
        end else if (kind == 0) begin
            m_addr = {j[31:2], 2'b00}; m_err = 1'b0; xfer = j[34] ? 1 : 0;
        end else begin
            m_err = 1'b0; xfer = 1;
        end
        @(posedge clk); #1;
        ta = 1'b0; tn = 1'b0; tb = 1'b0;
        if (xfer == 0) begin
            @(negedge clk);
            check_idle("noxfer");
            return;
        end
        done = 1'b0; accepted = 1'b0; c = 0; rdata = '0;
        while (!done) begin
            @(negedge clk);
            check("req", {30'd0, avm_read, avm_write}, (xfer == 1) ? 32'd2 : 32'd1);
            check("addr", avm_address, m_addr);
            check("busy", 32'(monitor_ready), 32'd0);
            if (xfer == 2) check("wdata", avm_writedata, m_data);
            stall = (c < stalls);
            avm_waitrequest = stall;
            rdata = mem.exists(m_addr) ? mem[m_addr] : $urandom;
            avm_readdata = stall ? $urandom : rdata;
            if (poke && c == 0) begin
                jdo = {6'($urandom), 32'($urandom)};
                case ($urandom_range(0, 2))
                    0: ta = 1'b1;
                    1: tn = 1'b1;
                    default: tb = 1'b1;
                endcase
            end
            @(posedge clk); #1;
            ta = 1'b0; tn = 1'b0; tb = 1'b0;
            if (!stall) begin
                accepted = 1'b1; done = 1'b1;
            end else if (c == TO) begin
                m_err = 1'b1; done = 1'b1;
            end
            c++;
        end
        avm_waitrequest = 1'b0;
        if (poke) m_err = 1'b1;
        if (accepted) begin
            if (xfer == 1) m_data = rdata;
            else mem[m_addr] = m_data;
            m_addr = m_addr + 32'd4;
        end
        @(negedge clk);
        check_idle("done");
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0; ta = 1'b0; tn = 1'b0; tb = 1'b0;
        avm_readdata = '0; avm_waitrequest = 1'b0;
        m_addr = '0; m_data = '0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_be", 32'(avm_byteenable), 32'hF);
        reset_n = 1'b1;

        // Directed cases
        run_cmd(0, mk_jdo(1'b0, 32'h0000_1003), 0, 0, 0);
        mem[32'h2000] = 32'hDEADBEEF;
        run_cmd(0, mk_jdo(1'b1, 32'h0000_2000), 2, 0, 0);
        check("rd_beef", MonDReg, 32'hDEADBEEF);
        run_cmd(2, mk_jdo(1'b0, 32'hCAFEF00D), 0, 0, 0);
        check("wr_next", MonAReg, 32'h2008);
        run_cmd(0, mk_jdo(1'b1, 32'h0000_4000), 20, 0, 0);
        check("timeout_err", 32'(monitor_error), 32'd1);
        run_cmd(0, mk_jdo(1'b0, 32'hFFFF_FFF8), 0, 0, 0);
        check("clear_err", 32'(monitor_error), 32'd0);
        for (int i = 0; i < 4; i++) run_cmd(1, '0, i, 0, 0);
        check("wrap", MonAReg, 32'h0000_0008);
        run_cmd(0, mk_jdo(1'b1, 32'h0000_5000), 3, 1, 0);
        run_cmd(2, mk_jdo(1'b0, 32'h1234_5678), 0, 0, 1);

        // Randomized command stream
        for (int n = 0; n < 150; n++) begin
            run_cmd($urandom_range(0, 2),
                    {6'($urandom), 32'($urandom_range(0, 63)) << 2 | 32'($urandom_range(0, 3))},
                    ($urandom_range(0, 9) == 0) ? 12 : $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset while a read is stalled
        @(negedge clk);
        jdo = mk_jdo(1'b1, 32'h0000_3000); ta = 1'b1;
        @(posedge clk); #1;
        ta = 1'b0; avm_waitrequest = 1'b1;
        @(negedge clk);
        check("rst_pre_read", 32'(avm_read), 32'd1);
        reset_n = 1'b0;
        #1;
        m_addr = '0; m_data = '0; m_err = 1'b0;
        check_idle("async_rst");
        @(negedge clk);
        reset_n = 1'b1; avm_waitrequest = 1'b0;
        run_cmd(0, mk_jdo(1'b1, 32'h0000_2000), 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
